// File: rtl/quote_dispatch_ctrl.sv
// Quote-to-order dispatcher: turns bid/ask quote pairs into buy/sell orders with a post-burst cooldown.
// Optional macro QUOTE_CROSS_CHECK_EN rejects crossed/locked quotes in IDLE.
module quote_dispatch_ctrl #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned COOLDOWN_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_quote_valid,
    input  logic [DATA_WIDTH-1:0] i_buy_price,
    input  logic [DATA_WIDTH-1:0] i_ask_price,
    input  logic                  i_enable,
    output logic                  o_order_valid,
    input  logic                  i_order_ready,
    output logic                  o_order_side,
    output logic [DATA_WIDTH-1:0] o_order_price,
    output logic                  o_busy,
    output logic [15:0]           o_drop_count
);

    typedef enum logic [1:0] {StIdle, StSendBid, StSendAsk, StCooldown} state_e;

    localparam logic [15:0] CoolLoad = 16'(COOLDOWN_CYCLES - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pend_bid_q, pend_bid_d, pend_ask_q, pend_ask_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [DATA_WIDTH-1:0] work_bid_q, work_bid_d, work_ask_q, work_ask_d;
    logic [DATA_WIDTH-1:0] last_bid_q, last_bid_d, last_ask_q, last_ask_d;
    logic [15:0]           cool_cnt_q, cool_cnt_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic [DATA_WIDTH-1:0] cand_bid, cand_ask;
    logic                  cand_valid, bid_changed, ask_changed, work_ask_changed;
    logic                  crossed, transfer;
    logic [1:0]            drop_inc;
    logic [16:0]           drop_sum;

    // An incoming quote always takes precedence over the pending one.
    always_comb begin
        cand_valid       = i_quote_valid | pend_flag_q;
        cand_bid         = i_quote_valid ? i_buy_price : pend_bid_q;
        cand_ask         = i_quote_valid ? i_ask_price : pend_ask_q;
        bid_changed      = (cand_bid != '0) && (cand_bid != last_bid_q);
        ask_changed      = (cand_ask != '0) && (cand_ask != last_ask_q);
        work_ask_changed = (work_ask_q != '0) && (work_ask_q != last_ask_q);
`ifdef QUOTE_CROSS_CHECK_EN
        crossed          = (cand_bid != '0) && (cand_ask != '0) && (cand_bid >= cand_ask);
`else
        crossed          = 1'b0;
`endif
    end

    assign o_order_valid = (state_q == StSendBid) || (state_q == StSendAsk);
    assign o_order_side  = (state_q == StSendAsk);
    assign o_order_price = (state_q == StSendAsk) ? work_ask_q :
                           (state_q == StSendBid) ? work_bid_q : '0;
    assign o_busy        = (state_q != StIdle);
    assign o_drop_count  = drop_cnt_q;
    assign transfer      = o_order_valid & i_order_ready;

    always_comb begin
        state_d     = state_q;
        pend_bid_d  = pend_bid_q;
        pend_ask_d  = pend_ask_q;
        pend_flag_d = pend_flag_q;
        work_bid_d  = work_bid_q;
        work_ask_d  = work_ask_q;
        last_bid_d  = last_bid_q;
        last_ask_d  = last_ask_q;
        cool_cnt_d  = cool_cnt_q;
        drop_inc    = 2'd0;

        // Outside IDLE (or IDLE while disabled) quotes park in pending; overwrites are drops.
        if (i_quote_valid && ((state_q != StIdle) || !i_enable)) begin
            pend_bid_d  = i_buy_price;
            pend_ask_d  = i_ask_price;
            pend_flag_d = 1'b1;
            if (pend_flag_q) drop_inc = 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (i_enable && cand_valid) begin
                    pend_flag_d = 1'b0;
                    if (i_quote_valid && pend_flag_q) drop_inc = 2'd1;
                    if (crossed) begin
                        drop_inc = drop_inc + 2'd1;
                    end else begin
                        work_bid_d = cand_bid;
                        work_ask_d = cand_ask;
                        if (bid_changed)      state_d = StSendBid;
                        else if (ask_changed) state_d = StSendAsk;
                    end
                end
            end
            StSendBid: begin
                if (transfer) begin
                    last_bid_d = work_bid_q;
                    if (work_ask_changed) begin
                        state_d = StSendAsk;
                    end else begin
                        state_d    = StCooldown;
                        cool_cnt_d = CoolLoad;
                    end
                end
            end
            StSendAsk: begin
                if (transfer) begin
                    last_ask_d = work_ask_q;
                    state_d    = StCooldown;
                    cool_cnt_d = CoolLoad;
                end
            end
            StCooldown: begin
                if (cool_cnt_q == 16'd0) state_d = StIdle;
                else                     cool_cnt_d = cool_cnt_q - 16'd1;
            end
            default: state_d = StIdle;
        endcase

        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            pend_bid_q  <= '0;
            pend_ask_q  <= '0;
            pend_flag_q <= 1'b0;
            work_bid_q  <= '0;
            work_ask_q  <= '0;
            last_bid_q  <= '0;
            last_ask_q  <= '0;
            cool_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_bid_q  <= pend_bid_d;
            pend_ask_q  <= pend_ask_d;
            pend_flag_q <= pend_flag_d;
            work_bid_q  <= work_bid_d;
            work_ask_q  <= work_ask_d;
            last_bid_q  <= last_bid_d;
            last_ask_q  <= last_ask_d;
            cool_cnt_q  <= cool_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_quote_dispatch_ctrl.sv
// Bench for quote_dispatch_ctrl: an order-queue reference model checked every cycle, directed
// scenarios with literal expectations, randomized traffic and drop-counter saturation.
module tb_quote_dispatch_ctrl;

    localparam int DW   = 32;
    localparam int COOL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          qv, en, ready;
    logic [DW-1:0] bid, ask;
    logic          o_valid, o_side, o_busy;
    logic [DW-1:0] o_price;
    logic [15:0]   o_drop;

    int checks = 0;
    int errors = 0;

    quote_dispatch_ctrl #(.DATA_WIDTH(DW), .COOLDOWN_CYCLES(COOL)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_quote_valid (qv),
        .i_buy_price   (bid),
        .i_ask_price   (ask),
        .i_enable      (en),
        .o_order_valid (o_valid),
        .i_order_ready (ready),
        .o_order_side  (o_side),
        .o_order_price (o_price),
        .o_busy        (o_busy),
        .o_drop_count  (o_drop)
    );

    always #5 clk = ~clk;

    // Model: a burst is the list of orders still owed, followed by a cooldown countdown.
    typedef struct packed {
        logic          side;
        logic [DW-1:0] price;
    } ord_t;

    ord_t          oq[$];
    int            m_cool;
    int            m_drop;
    logic [DW-1:0] m_last_bid, m_last_ask, m_pbid, m_pask;
    logic          m_pflag;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int            drops;
        logic [DW-1:0] cb, ca;
        bit            idle, crossed;
        ord_t          o;
        if (rst) begin
            oq.delete();
            m_cool = 0; m_drop = 0; m_pflag = 0;
            m_last_bid = '0; m_last_ask = '0; m_pbid = '0; m_pask = '0;
            return;
        end
        drops = 0;
        idle  = (oq.size() == 0) && (m_cool == 0);
        if (idle && en) begin
            if (qv || m_pflag) begin
                if (qv && m_pflag) drops++;
                cb = qv ? bid : m_pbid;
                ca = qv ? ask : m_pask;
                m_pflag = 0;
                crossed = 0;
`ifdef QUOTE_CROSS_CHECK_EN
                crossed = (cb != 0) && (ca != 0) && (cb >= ca);
`endif
                if (crossed) begin
                    drops++;
                end else begin
                    if (cb != 0 && cb != m_last_bid) oq.push_back('{side: 1'b0, price: cb});
                    if (ca != 0 && ca != m_last_ask) oq.push_back('{side: 1'b1, price: ca});
                end
            end
        end else begin
            if (qv) begin
                if (m_pflag) drops++;
                m_pbid = bid; m_pask = ask; m_pflag = 1;
            end
            if (oq.size() > 0) begin
                if (ready) begin
                    o = oq.pop_front();
                    if (o.side) m_last_ask = o.price;
                    else        m_last_bid = o.price;
                    if (oq.size() == 0) m_cool = COOL;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end
        end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    endtask

    task automatic compare();
        bit exp_valid;
        exp_valid = (oq.size() > 0);
        chk("order_valid", DW'(o_valid), DW'(exp_valid));
        chk("busy", DW'(o_busy), DW'((oq.size() > 0) || (m_cool > 0)));
        chk("drop_count", DW'(o_drop), DW'(m_drop));
        if (exp_valid) begin
            chk("order_side", DW'(o_side), DW'(oq[0].side));
            chk("order_price", o_price, oq[0].price);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic quote(input logic [DW-1:0] b, input logic [DW-1:0] a);
        qv = 1'b1; bid = b; ask = a;
        cycle();
        qv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && o_busy; i++) cycle();
        chk("idle_reached", DW'(o_busy), '0);
    endtask

    initial begin
        int n;
        rst = 1'b1; qv = 1'b0; en = 1'b1; ready = 1'b1; bid = '0; ask = '0;
        cycle();
        cycle();
        chk("reset_valid", DW'(o_valid), '0);
        chk("reset_busy", DW'(o_busy), '0);
        chk("reset_price", o_price, '0);
        chk("reset_side", DW'(o_side), '0);
        chk("reset_drop", DW'(o_drop), '0);
        rst = 1'b0;

        // Basic burst: buy then sell on consecutive cycles, then a 16-cycle cooldown.
        quote(100, 102);
        chk("b1_valid", DW'(o_valid), 1);
        chk("b1_side", DW'(o_side), 0);
        chk("b1_price", o_price, 100);
        cycle();
        chk("b1_ask_side", DW'(o_side), 1);
        chk("b1_ask_price", o_price, 102);
        cycle();
        n = 0;
        for (int i = 0; i < 40 && o_busy; i++) begin
            n++;
            cycle();
        end
        chk("cooldown_len", DW'(n), DW'(COOL));

        // Same prices again: nothing to send, nothing dropped.
        quote(100, 102);
        chk("repeat_valid", DW'(o_valid), 0);
        chk("repeat_busy", DW'(o_busy), 0);
        chk("repeat_drop", DW'(o_drop), 0);

        // Backpressure: buy held stable while ready is low.
        do_reset();
        ready = 1'b0;
        quote(100, 103);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", DW'(o_valid), 1);
            chk("hold_price", o_price, 100);
            chk("hold_side", DW'(o_side), 0);
            cycle();
        end
        ready = 1'b1;
        chk("hold_last_price", o_price, 100);
        cycle();
        chk("hold_ask_side", DW'(o_side), 1);
        chk("hold_ask_price", o_price, 103);
        cycle();

        // Three quotes during cooldown: only the newest survives, two drops.
        quote(101, 104);
        quote(99, 104);
        quote(98, 105);
        for (int i = 0; i < 60 && !o_valid; i++) cycle();
        chk("cd_buy_price", o_price, 98);
        chk("cd_buy_side", DW'(o_side), 0);
        cycle();
        chk("cd_sell_price", o_price, 105);
        chk("cd_sell_side", DW'(o_side), 1);
        chk("cd_drop", DW'(o_drop), 2);
        cycle();
        wait_idle();

        // Locked quote.
        do_reset();
        quote(105, 105);
`ifdef QUOTE_CROSS_CHECK_EN
        chk("lock_valid", DW'(o_valid), 0);
        chk("lock_drop", DW'(o_drop), 1);
`else
        chk("lock_buy_price", o_price, 105);
        cycle();
        chk("lock_sell_side", DW'(o_side), 1);
        chk("lock_sell_price", o_price, 105);
`endif
        cycle();
        wait_idle();

        // Reset while the buy waits on ready.
        do_reset();
        ready = 1'b0;
        quote(100, 102);
        cycle();
        chk("rst_mid_valid_before", DW'(o_valid), 1);
        do_reset();
        chk("rst_mid_valid_after", DW'(o_valid), 0);
        ready = 1'b1;
        quote(100, 102);
        chk("rst_mid_buy", o_price, 100);
        cycle();
        chk("rst_mid_sell", o_price, 102);

        // Randomized traffic with small price range so repeats and zeros are common.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            qv    = ($urandom_range(0, 9) < 3);
            en    = ($urandom_range(0, 9) < 8);
            ready = ($urandom_range(0, 9) < 7);
            bid   = DW'($urandom_range(0, 6));
            ask   = DW'($urandom_range(0, 6));
            cycle();
        end

        // Saturation: disabled in IDLE, every quote overwrites the pending one.
        rst = 1'b0; qv = 1'b0; ready = 1'b1; en = 1'b1;
        do_reset();
        en = 1'b0;
        qv = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            bid = DW'($urandom_range(1, 50));
            ask = DW'($urandom_range(51, 99));
            cycle();
        end
        chk("drop_saturated", DW'(o_drop), 32'h0000_FFFF);
        qv = 1'b0;
        en = 1'b1;
        cycle();
        chk("drop_sat_hold", DW'(o_drop), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quote_dispatch_ctrl.md
QUOTE_DISPATCH_CTRL -- requirements
Module: quote_dispatch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: price width in integer ticks.
REQ-002 Parameter COOLDOWN_CYCLES, default 16, legal range 1..65535: minimum idle gap after a quote burst.
REQ-003 One clock, i_clk; reset is synchronous and active-high, named i_reset.
REQ-004 i_clk  input  1  clock; all logic on the rising edge.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_quote_valid  input  1  new quote pair present this cycle.
REQ-007 i_buy_price  input  DATA_WIDTH  new bid price.
REQ-008 i_ask_price  input  DATA_WIDTH  new ask price.
REQ-009 i_enable  input  1  trading enable; gates the start of new bursts only.
REQ-010 o_order_valid  output  1  order request to downstream.
REQ-011 i_order_ready  input  1  downstream accepts; a transfer occurs when valid and ready are both high.
REQ-012 o_order_side  output  1  0 = buy, 1 = sell.
REQ-013 o_order_price  output  DATA_WIDTH  order price.
REQ-014 o_busy  output  1  high whenever state is not IDLE.
REQ-015 o_drop_count  output  16  saturating count of superseded or rejected quotes.

Function
REQ-016 The FSM SHALL have four states, IDLE, SEND_BID, SEND_ASK and COOLDOWN, encoded in registers.
REQ-017 Pending register: a quote arriving outside IDLE is stored in pending (bid, ask, flag); a newer quote overwrites it, and each overwrite of a set flag increments o_drop_count.
REQ-018 In IDLE the candidate is the incoming quote if i_quote_valid is high, else pending if its flag is set; an incoming quote wins over pending, and the dropped pending increments o_drop_count.
REQ-019 A side is "changed" when its candidate price is nonzero and differs from that side's last-sent register; zero prices are never sent.
REQ-020 IDLE with i_enable high and a candidate:
- bid changed -> SEND_BID
- else ask changed -> SEND_ASK
- else discard silently.
- On any of these, latch the candidate into the working registers and clear the pending flag.
REQ-021 IDLE with i_enable low: no transition; an incoming quote is written to pending.
REQ-022 With i_quote_valid seen at edge N, o_order_valid SHALL be high in the cycle after edge N.
REQ-023 SEND_BID and SEND_ASK:
- o_order_valid is high, side is 0 or 1 respectively, price comes from the working register.
- Outputs are held stable until the transfer.
- i_enable falling mid-burst does not abort the burst.
REQ-024 Transfer in SEND_BID: update last-sent bid, then go to SEND_ASK if ask changed, else COOLDOWN.
REQ-025 Transfer in SEND_ASK: update last-sent ask, then go to COOLDOWN.
REQ-026 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, then return to IDLE.
REQ-027 o_order_valid SHALL be low in IDLE and COOLDOWN.
REQ-028 A quote arriving in the same cycle as a transfer goes to pending.
REQ-029 o_drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-030 While i_reset is high at an edge, the following SHALL clear to zero:
- state -> IDLE
- o_order_valid, o_order_side, o_order_price, o_busy
- o_drop_count, the pending flag and prices
- last-sent registers and the cooldown counter.
REQ-031 Reset during a handshake SHALL drop o_order_valid after that edge, with no transfer counted.
REQ-032 Reset SHALL take priority over all other inputs.

Configuration
REQ-033 Macro QUOTE_CROSS_CHECK_EN defined: in IDLE, a candidate with nonzero bid >= nonzero ask is rejected (no state change, o_drop_count +1).
REQ-034 Macro QUOTE_CROSS_CHECK_EN undefined: crossed and locked quotes are dispatched like any other quote.

Verification
REQ-035 Reset, then quote bid=100/ask=102 with ready held high -> buy@100, then sell@102 on consecutive cycles, then o_busy high for 16 cycles, then IDLE.
REQ-036 Repeat 100/102 after the cooldown -> no order; o_drop_count stays 0.
REQ-037 Quote 100/103 while ready is low for 5 cycles -> buy@100 held stable for 5 cycles; only sell@103 is sent after the transfer.
REQ-038 Three quotes during COOLDOWN (101/104, 99/104, 98/105) -> after the cooldown, buy@98 and sell@105 are sent; o_drop_count=2.
REQ-039 Quote 105/105: with QUOTE_CROSS_CHECK_EN -> no order and o_drop_count +1; without it -> buy@105 and sell@105 are sent.
REQ-040 Assert i_reset while SEND_BID is waiting -> o_order_valid low after the edge; the next quote 100/102 sends both sides again.
